// File: rtl/src_alu_mc.sv
// src_alu_mc: bus-attached ALU with single-cycle ops into C and an
// iterative MUL/DIV engine writing HI/LO after WIDTH+1 cycles.
// Ports: clk, reset (sync, active-high), cpu_bus (shared inout),
//   a_in (load A), op/op_go (execute, B = bus),
//   c_out/hi_out/lo_out (drive bus), busy, done, div_zero.
module src_alu_mc #(
  parameter int WIDTH    = 32,
  parameter int INC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] cpu_bus,
  input  logic             a_in,
  input  logic [3:0]       op,
  input  logic             op_go,
  input  logic             c_out,
  input  logic             hi_out,
  input  logic             lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WM1 = WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, c_q, hi_q, lo_q;
  logic [WIDTH-1:0] wa, wb, wd;
  logic [WIDTH-1:0] wa_n, wb_n;
  logic [CW-1:0]    cnt;
  logic             is_div;

  logic [WIDTH-1:0] drv_val, bval, alu_res;
  logic             drv_en, alu_ok, start, last, idle;
  logic             big;
  logic [CW-1:0]    sh;
  logic [WIDTH:0]   msum, dsh;
  logic             ge;

  // Bus drive; never driven during reset.
  assign drv_en = (c_out | hi_out | lo_out) & ~reset;

  always_comb begin
    drv_val = lo_q;
    if (c_out)       drv_val = c_q;
    else if (hi_out) drv_val = hi_q;
  end

  assign cpu_bus = drv_en ? drv_val : 'z;

  // When we drive the bus ourselves, use our own value as the operand.
  assign bval = drv_en ? drv_val : cpu_bus;

  assign idle = (state == IDLE);
  assign busy = ~idle;
  assign done = (state == DONE);
  assign last = (cnt == LAST);

  assign big = (bval > WM1);
  assign sh  = bval[CW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (op)
      4'd0:    alu_res = a_q + bval;
      4'd1:    alu_res = a_q - bval;
      4'd2:    alu_res = a_q & bval;
      4'd3:    alu_res = a_q | bval;
      4'd4:    alu_res = big ? '0 : (a_q >> sh);
      4'd5:    alu_res = big ? {WIDTH{a_q[WIDTH-1]}}
                             : WIDTH'($signed(a_q) >>> sh);
      4'd6:    alu_res = big ? '0 : (a_q << sh);
      4'd7:    alu_res = ~a_q;
      4'd8:    alu_res = bval;
      4'd9:    alu_res = a_q + WIDTH'(INC_STEP);
      4'd10:   alu_res = '0 - a_q;
      default: alu_ok  = 1'b0;
    endcase
  end

  assign start = op_go & idle & ((op == 4'd11) | (op == 4'd12));

  // One iteration: MUL shifts {wa,wb} right after a conditional add;
  // DIV shifts the dividend into the remainder and restores on borrow.
  // A zero divisor naturally yields all-ones quotient and rem = A.
  always_comb begin
    msum = {1'b0, wa} + {1'b0, (wb[0] ? wd : '0)};
    dsh  = {wa, wb[WIDTH-1]};
    ge   = (dsh >= {1'b0, wd});
    if (is_div) begin
      wa_n = ge ? WIDTH'(dsh - {1'b0, wd}) : dsh[WIDTH-1:0];
      wb_n = {wb[WIDTH-2:0], ge};
    end else begin
      wa_n = msum[WIDTH:1];
      wb_n = {msum[0], wb[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      c_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      wa       <= '0;
      wb       <= '0;
      wd       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (a_in) a_q <= bval;
      if (op_go && idle && alu_ok) c_q <= alu_res;
      if (start) begin
        wa       <= '0;
        wb       <= a_q;
        wd       <= bval;
        cnt      <= '0;
        is_div   <= (op == 4'd12);
        div_zero <= (op == 4'd12) && (bval == '0);
      end
      if (state == RUN) begin
        wa  <= wa_n;
        wb  <= wb_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi_q <= wa_n;
          lo_q <= wb_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_src_alu_mc.sv
// tb_src_alu_mc: directed and randomized checks of src_alu_mc
// against a plain-arithmetic reference model.
module tb_src_alu_mc;

  logic        clk = 0;
  logic        reset = 1;
  logic        a_in = 0;
  logic [3:0]  op = 0;
  logic        op_go = 0;
  logic        c_out = 0;
  logic        hi_out = 0;
  logic        lo_out = 0;
  logic        busy, done, div_zero;
  logic [31:0] drv = 0;
  logic        drv_en = 0;
  wire  [31:0] bus;

  assign bus = drv_en ? drv : 'z;

  src_alu_mc #(.WIDTH(32), .INC_STEP(4)) dut (
    .clk(clk), .reset(reset), .cpu_bus(bus), .a_in(a_in),
    .op(op), .op_go(op_go), .c_out(c_out), .hi_out(hi_out),
    .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_m, c_m, hi_m, lo_m;
  logic        dz_m;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(int o, logic [31:0] a,
                                          logic [31:0] b);
    longint sa;
    int     s;
    logic [63:0] w;
    s  = (b > 63) ? 63 : int'(b);
    sa = longint'($signed(a));
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: begin w = {32'd0, a} >> s; return w[31:0]; end
      5: begin w = sa >>> s; return w[31:0]; end
      6: begin w = {32'd0, a} << s; return (b > 31) ? 32'd0 : w[31:0]; end
      7: return ~a;
      8: return b;
      9: return a + 32'd4;
      10: return ~a + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic load_a(logic [31:0] v);
    a_in = 1; drv = v; drv_en = 1;
    cyc();
    a_in = 0; drv_en = 0;
    a_m = v;
  endtask

  task automatic do_op(int o, logic [31:0] b);
    op = 4'(o); op_go = 1; drv = b; drv_en = 1;
    cyc();
    op_go = 0; drv_en = 0;
    if (o <= 10) c_m = ref_alu(o, a_m, b);
  endtask

  task automatic rd(int sel, output logic [31:0] v);
    c_out = (sel == 0); hi_out = (sel == 1); lo_out = (sel == 2);
    #1;
    v = bus;
    c_out = 0; hi_out = 0; lo_out = 0;
    #1;
  endtask

  task automatic chk_c(string tag);
    logic [31:0] v;
    rd(0, v);
    chk(tag, 64'(v), 64'(c_m));
  endtask

  task automatic chk_hilo(string tag);
    logic [31:0] v;
    rd(1, v);
    chk({tag, "_hi"}, 64'(v), 64'(hi_m));
    rd(2, v);
    chk({tag, "_lo"}, 64'(v), 64'(lo_m));
    chk({tag, "_dz"}, 64'(div_zero), 64'(dz_m));
  endtask

  // Start MUL/DIV, measure latency to done and busy width.
  task automatic run_md(string tag, int o, logic [31:0] b);
    int n, nb;
    logic [63:0] p;
    do_op(o, b);
    n = 1; nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      cyc();
      n++;
    end
    if (busy === 1'b1) nb++;
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(nb), 64'd33);
    if (o == 11) begin
      p = {32'd0, a_m} * {32'd0, b};
      hi_m = p[63:32]; lo_m = p[31:0]; dz_m = 0;
    end else if (b == 0) begin
      hi_m = a_m; lo_m = '1; dz_m = 1;
    end else begin
      hi_m = a_m % b; lo_m = a_m / b; dz_m = 0;
    end
    cyc();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk_hilo(tag);
  endtask

  initial begin
    logic [31:0] v, zz, ra, rb;
    int o, n, seen;
    zz = 'z;
    a_m = 0; c_m = 0; hi_m = 0; lo_m = 0; dz_m = 0;

    reset = 1; c_out = 1;
    cyc(); cyc();
    chk("rst_bus_z", 64'(bus), 64'(zz));
    c_out = 0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 0;
    cyc();
    chk_c("rst_c");
    chk_hilo("rst");

    load_a(7);
    do_op(0, 5);
    chk_c("add");
    do_op(1, 9);
    chk("sub", 64'(c_m), 64'hFFFFFFFE);
    chk_c("sub_bus");

    load_a(32'h80000000);
    do_op(5, 4);
    chk_c("shra");
    chk("shra_const", 64'(c_m), 64'hF8000000);
    do_op(4, 40);
    chk_c("shr40");
    do_op(5, 32);
    chk_c("shra32");
    load_a(1);
    do_op(6, 31);
    chk_c("shl31");
    do_op(6, 32);
    chk_c("shl32");
    do_op(9, 0);
    chk_c("inc");
    do_op(10, 0);
    chk_c("neg");

    // a_in with op_go: op uses old A, A takes bus.
    load_a(7);
    a_in = 1; op = 0; op_go = 1; drv = 3; drv_en = 1;
    cyc();
    a_in = 0; op_go = 0; drv_en = 0;
    c_m = 10; a_m = 3;
    chk_c("ain_go_c");
    do_op(8, 0);
    do_op(7, 0);
    chk_c("ain_go_a");

    // No-op codes leave C untouched.
    do_op(13, 5);
    chk_c("nop13");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      o  = int'($urandom_range(0, 10));
      rb = (o >= 4 && o <= 6) ? $urandom_range(0, 40) : $urandom;
      load_a(ra);
      do_op(o, rb);
      chk_c($sformatf("rnd_op%0d", o));
    end

    load_a(32'hFFFFFFFF);
    run_md("mul", 11, 2);
    chk("mul_hi_const", 64'(hi_m), 64'd1);

    load_a(100);
    run_md("div", 12, 7);
    chk("div_lo_const", 64'(lo_m), 64'd14);
    run_md("div0", 12, 0);
    run_md("mul_clr_dz", 11, 3);

    for (int i = 0; i < 6; i++) begin
      load_a($urandom);
      rb = (i == 5) ? 32'd1 : $urandom_range(1, 32'hFFFF);
      run_md($sformatf("rnd_md%0d", i), (i % 2) ? 12 : 11, rb);
    end

    // op_go and a_in during RUN.
    load_a(32'h12345678);
    do_op(0, 1);
    ra = a_m;
    rb = 32'h9ABCDEF1;
    op = 11; op_go = 1; drv = rb; drv_en = 1;
    cyc();
    op_go = 0; drv_en = 0;
    cyc(); cyc();
    op = 0; op_go = 1; drv = 99; drv_en = 1;
    cyc();
    op_go = 0; drv_en = 0;
    a_in = 1; drv = 32'h55; drv_en = 1;
    cyc();
    a_in = 0; drv_en = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("run_done_seen", 64'(done), 64'd1);
    {hi_m, lo_m} = {32'd0, ra} * {32'd0, rb};
    dz_m = 0;
    cyc();
    chk_hilo("run_mul");
    chk_c("run_c_kept");
    a_m = 32'h55;
    do_op(7, 0);
    chk_c("run_a_new");

    // Reset in the middle of RUN.
    load_a(32'hDEADBEEF);
    do_op(11, 77);
    repeat (5) cyc();
    reset = 1;
    cyc();
    reset = 0;
    chk("rst_run_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      cyc();
    end
    chk("rst_run_nodone", 64'(seen), 64'd0);
    a_m = 0; c_m = 0; hi_m = 0; lo_m = 0; dz_m = 0;
    chk_hilo("rst_run");

    // Bus priority and release.
    load_a(32'h11);
    do_op(8, 32'hCAFE);
    c_out = 1; hi_out = 1;
    #1;
    chk("prio_c_hi", 64'(bus), 64'(c_m));
    c_out = 0; hi_out = 0;
    #1;
    chk("bus_z", 64'(bus), 64'(zz));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/src_alu_mc.md
SRC_ALU_MC -- requirements
Module: src_alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath and bus width; legal values are 8 to 64, powers of two.
REQ-002 The block SHALL have parameter INC_STEP, default 4, giving the constant added by the INC operation.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cpu_bus, inout, WIDTH bits: the shared CPU bus, operand source and result sink.
REQ-006 The block SHALL have port a_in, input, 1 bit: load register A from cpu_bus.
REQ-007 The block SHALL have port op, input, 4 bits: operation code.
REQ-008 The block SHALL have port op_go, input, 1 bit: execute op this cycle, with B = cpu_bus.
REQ-009 The block SHALL have ports c_out, hi_out and lo_out, each input, 1 bit: drive C, HI or LO onto cpu_bus.
REQ-010 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are updated.
REQ-012 The block SHALL have port div_zero, output, 1 bit: the last DIV had divisor 0; sticky until the next MUL/DIV start.

Function
REQ-013 Op codes SHALL be: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 NOT ~A, 8 PASS B, 9 INC A+INC_STEP, 10 NEG -A, 11 MUL, 12 DIV; codes 13-15 are no-ops.
REQ-014 a_in SHALL load A <= cpu_bus at the clock edge; A and B are unsigned except for SHRA, and all results are truncated to WIDTH bits.
REQ-015 Single-cycle ops (0-10) with op_go=1 SHALL write C at that clock edge, so the result is visible on the bus the next cycle.
REQ-016 Shift amount SHALL be B as an unsigned value; for amounts >= WIDTH, SHR and SHL give 0 and SHRA gives WIDTH copies of A[WIDTH-1].
REQ-017 If a_in and op_go are both set in one cycle, the op SHALL use the old A, and A SHALL take the bus value.
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 In IDLE, op_go with MUL or DIV SHALL latch the operands A and B and go to RUN.
REQ-020 RUN SHALL last exactly WIDTH cycles using an iterative shift-add (MUL) or restoring shift-subtract (DIV) algorithm, then go to DONE.
REQ-021 On entry to DONE, HI and LO SHALL be written and done=1 for that single cycle; the next state is IDLE.
REQ-022 Total latency from the op_go edge to the done cycle SHALL be WIDTH+1 cycles.
REQ-023 MUL SHALL produce the unsigned 2*WIDTH-bit product: HI = upper half, LO = lower half.
REQ-024 DIV SHALL produce LO = quotient and HI = remainder.
REQ-025 DIV with B=0 SHALL still take full latency, give LO = all ones and HI = A, and set div_zero=1.
REQ-026 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-027 op_go SHALL be ignored entirely (no C write, no start) while busy=1.
REQ-028 a_in while busy SHALL update A without affecting the operation in progress.
REQ-029 cpu_bus SHALL be driven only when at least one of c_out, hi_out or lo_out is set, with priority c_out > hi_out > lo_out; otherwise it is high-impedance.
REQ-030 The block SHALL never sample cpu_bus in a cycle in which it drives it: op_go or a_in together with any *_out is a caller error, and the block still uses its own driven value.

Reset
REQ-031 reset SHALL clear A, C, HI, LO, the iteration counter, busy, done and div_zero to 0, and force IDLE at the clock edge.
REQ-032 reset SHALL take priority over every other input in the same cycle.
REQ-033 reset during RUN or DONE SHALL abort the operation with no done pulse and no HI/LO update.
REQ-034 cpu_bus SHALL be high-impedance while reset is asserted.

Verification
REQ-035 (WIDTH=32) a_in with bus=7; op_go ADD with bus=5; c_out -> bus=12 one cycle after op_go; SUB with bus=9 -> C=0xFFFFFFFE.
REQ-036 A=0x80000000; SHRA with bus=4 -> 0xF8000000; SHR with bus=40 -> 0; SHL with bus=31 on A=1 -> 0x80000000.
REQ-037 A=0xFFFFFFFF; MUL with bus=2 -> busy for 33 cycles, done on the 33rd cycle after op_go; then HI=1, LO=0xFFFFFFFE.
REQ-038 A=100; DIV with bus=7 -> LO=14, HI=2, div_zero=0; DIV with bus=0 -> LO=0xFFFFFFFF, HI=100, div_zero=1.
REQ-039 During RUN, an op_go ADD is ignored (C unchanged) and an a_in is accepted without corrupting the MUL result; reset asserted mid-RUN -> busy=0 next cycle, no done pulse, HI=LO=0.
REQ-040 c_out and hi_out both set -> bus=C; no *_out set -> bus=Z.
